// File: rtl/de10lite_qsys_pio_key_in_if.sv
// ============================================================================
// Module  : de10lite_qsys_pio_key_in_if
// Brief   : Avalon-MM slave bus bundle for the key/switch input PIO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface de10lite_qsys_pio_key_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

`default_nettype wire

// File: rtl/de10lite_qsys_pio_key_in.sv
// ============================================================================
// Module  : de10lite_qsys_pio_key_in
// Brief   : Input PIO: synchronise, debounce and edge-capture board inputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module de10lite_qsys_pio_key_in #(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
    input  logic                       clk,
    input  logic                       reset,
    de10lite_qsys_pio_key_in_if.slave  bus,
    input  logic [WIDTH-1:0]           in_port
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_deb_nxt;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_rdata;
    logic             w_wr;

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= RESET_VALUE;
            r_sync2 <= RESET_VALUE;
            r_deb   <= RESET_VALUE;
            r_prev  <= RESET_VALUE;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
            r_deb   <= w_deb_nxt;
            r_prev  <= r_deb;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign w_deb_nxt = r_sync2;
        end else begin : g_debounce
            localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CNT_W-1:0] r_cnt;
                logic             w_accept;

                // The counter only runs while the input disagrees with the
                // accepted level, so it stops at CNT_MAX and never wraps.
                assign w_accept     = (r_sync2[i] != r_deb[i]) && (r_cnt == CNT_MAX);
                assign w_deb_nxt[i] = w_accept ? r_sync2[i] : r_deb[i];

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_cnt <= '0;
                    end else if (r_sync2[i] == r_deb[i] || w_accept) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_ev = '0;
        case (EDGE_TYPE)
            0:       w_ev = r_deb & ~r_prev;
            1:       w_ev = ~r_deb & r_prev;
            default: w_ev = r_deb ^ r_prev;
        endcase
    end

    // A new edge is OR-ed in after the clear, so it survives a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (w_wr && bus.address == 2'd2) begin
                r_irqmask <= w_wdata;
            end
            if (w_wr && bus.address == 2'd3) begin
                r_edgecap <= (r_edgecap & ~w_wdata) | w_ev;
            end else begin
                r_edgecap <= r_edgecap | w_ev;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            2'd0:    w_rdata[WIDTH-1:0] = r_deb;
            2'd2:    w_rdata[WIDTH-1:0] = r_irqmask;
            2'd3:    w_rdata[WIDTH-1:0] = r_edgecap;
            default: w_rdata = '0;
        endcase
    end

    assign bus.readdata = w_rdata;
    assign bus.irq      = |(r_edgecap & r_irqmask);

    generate
        if (WIDTH < 32) begin : g_wdata_tail
            logic w_unused_wdata;
            assign w_unused_wdata = &{1'b0, bus.writedata[31:WIDTH]};
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_de10lite_qsys_pio_key_in.sv
// ============================================================================
// Module  : tb_de10lite_qsys_pio_key_in
// Brief   : Self-checking bench: register table, directed corners, random run.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_de10lite_qsys_pio_key_in;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_port;
    logic [1:0]  address;
    logic        cs;
    logic        wn;
    logic [31:0] wd;

    de10lite_qsys_pio_key_in_if bus1 ();
    de10lite_qsys_pio_key_in_if bus2 ();

    assign bus1.address    = address;
    assign bus1.chipselect = cs;
    assign bus1.write_n    = wn;
    assign bus1.writedata  = wd;
    assign bus2.address    = address;
    assign bus2.chipselect = cs;
    assign bus2.write_n    = wn;
    assign bus2.writedata  = wd;

    de10lite_qsys_pio_key_in #(.WIDTH(2), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port));
    de10lite_qsys_pio_key_in #(.WIDTH(2), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] e1, input logic [31:0] e2);
        address = a;
        #1;
        chk({nm, "/falling"}, bus1.readdata, e1);
        chk({nm, "/any"}, bus2.readdata, e2);
    endtask

    task automatic chk_irq(input string nm, input logic e1, input logic e2);
        chk({nm, "/irq_falling"}, {31'd0, bus1.irq}, {31'd0, e1});
        chk({nm, "/irq_any"}, {31'd0, bus2.irq}, {31'd0, e2});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; wd = d; cs = 1'b1; wn = 1'b0;
        tick();
        cs = 1'b0; wn = 1'b1;
    endtask

    // Reference model: a level is accepted once the last N synchronised
    // samples all disagree with the currently accepted level.
    logic [1:0] m_s1, m_s2, m_deb, m_prev, m_mask, m_ec1, m_ec2;
    logic [1:0] hist[$];

    always @(posedge clk) begin : model
        logic [1:0] f, r, nd;
        bit         all_diff;
        if (reset) begin
            m_s1 = 2'b11; m_s2 = 2'b11; m_deb = 2'b11; m_prev = 2'b11;
            m_mask = 2'b00; m_ec1 = 2'b00; m_ec2 = 2'b00;
            hist.delete();
        end else begin
            f = ~m_deb & m_prev;
            r = m_deb & ~m_prev;
            hist.push_back(m_s2);
            if (hist.size() > N) void'(hist.pop_front());
            nd = m_deb;
            if (hist.size() == N) begin
                for (int b = 0; b < 2; b++) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
                    if (all_diff) nd[b] = m_s2[b];
                end
            end
            if (cs && !wn && address == 2'd3) begin
                m_ec1 = (m_ec1 & ~wd[1:0]) | f;
                m_ec2 = (m_ec2 & ~wd[1:0]) | f | r;
            end else begin
                m_ec1 = m_ec1 | f;
                m_ec2 = m_ec2 | f | r;
            end
            if (cs && !wn && address == 2'd2) m_mask = wd[1:0];
            m_prev = m_deb;
            m_deb  = nd;
            m_s2   = m_s1;
            m_s1   = in_port;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic [1:0] ec);
        case (a)
            2'd0:    return {30'd0, m_deb};
            2'd2:    return {30'd0, m_mask};
            2'd3:    return {30'd0, ec};
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int hold;

        vecs[0] = '{2'd0, 1'b0, 1'b1, 32'h0,        32'h3, 1'b0};
        vecs[1] = '{2'd1, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        vecs[2] = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        vecs[3] = '{2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        vecs[4] = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h3, 1'b0};
        vecs[5] = '{2'd0, 1'b1, 1'b0, 32'h0,        32'h3, 1'b0};
        vecs[6] = '{2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[7] = '{2'd2, 1'b0, 1'b0, 32'h0,        32'h3, 1'b0};
        vecs[8] = '{2'd2, 1'b1, 1'b0, 32'h1,        32'h1, 1'b0};
        vecs[9] = '{2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};

        reset = 1'b1; in_port = 2'b00; address = 2'd0; cs = 1'b0; wn = 1'b1; wd = '0;

        // Reset with keys held low: idle value first, then both bits fall.
        repeat (3) tick();
        reset = 1'b0;
        tick();
        rd(2'd0, "t1_data_after_reset", 32'h3, 32'h3);
        chk_irq("t1_after_reset", 1'b0, 1'b0);
        rd(2'd3, "t1_ecap_after_reset", 32'h0, 32'h0);
        repeat (4) tick();
        rd(2'd0, "t1_data_clk5", 32'h3, 32'h3);
        tick();
        rd(2'd0, "t1_data_clk6", 32'h0, 32'h0);
        rd(2'd3, "t1_ecap_clk6", 32'h0, 32'h0);
        tick();
        rd(2'd3, "t1_ecap_clk7", 32'h3, 32'h3);
        chk_irq("t1_masked", 1'b0, 1'b0);

        // Register-map table with keys idle.
        reset = 1'b1; in_port = 2'b11;
        repeat (3) tick();
        reset = 1'b0;
        repeat (8) tick();
        for (int v = 0; v < 10; v++) begin
            address = vecs[v].a; cs = vecs[v].cs; wn = vecs[v].wn; wd = vecs[v].d;
            tick();
            cs = 1'b0; wn = 1'b1;
            chk($sformatf("tbl%0d_rd", v), bus1.readdata, vecs[v].exp_rd);
            chk($sformatf("tbl%0d_rd_any", v), bus2.readdata, vecs[v].exp_rd);
            chk_irq($sformatf("tbl%0d", v), vecs[v].exp_irq, vecs[v].exp_irq);
        end
        wr(2'd2, 32'h0);

        // Clean press on bit0, then unmask.
        in_port = 2'b10;
        repeat (5) tick();
        rd(2'd0, "t2_data_clk5", 32'h3, 32'h3);
        tick();
        rd(2'd0, "t2_data_clk6", 32'h2, 32'h2);
        rd(2'd3, "t2_ecap_clk6", 32'h0, 32'h0);
        tick();
        rd(2'd3, "t2_ecap_clk7", 32'h1, 32'h1);
        chk_irq("t2_masked", 1'b0, 1'b0);
        address = 2'd2; wd = 32'h1; cs = 1'b1; wn = 1'b0;
        #1;
        chk_irq("t2_before_mask", 1'b0, 1'b0);
        tick();
        cs = 1'b0; wn = 1'b1;
        chk("t2_mask_rd", bus1.readdata, 32'h1);
        chk_irq("t2_after_mask", 1'b1, 1'b1);
        wr(2'd3, 32'hFFFFFFFF);
        rd(2'd3, "t2_cleared", 32'h0, 32'h0);
        chk_irq("t2_cleared", 1'b0, 1'b0);

        // Release of bit0: only the any-edge instance captures it.
        in_port = 2'b11;
        repeat (10) tick();
        rd(2'd0, "t5_data", 32'h3, 32'h3);
        rd(2'd3, "t5_ecap", 32'h0, 32'h1);
        chk_irq("t5", 1'b0, 1'b1);
        wr(2'd3, 32'h1);

        // Glitch of 3 sync cycles on bit1 must be rejected.
        in_port = 2'b01;
        repeat (3) tick();
        in_port = 2'b11;
        for (int c = 0; c < 12; c++) begin
            tick();
            rd(2'd0, $sformatf("t3_glitch_data%0d", c), 32'h3, 32'h3);
        end
        rd(2'd3, "t3_glitch_ecap", 32'h0, 32'h0);

        // 4 sync cycles is accepted.
        in_port = 2'b01;
        repeat (4) tick();
        in_port = 2'b11;
        repeat (2) tick();
        rd(2'd0, "t3_accept_data", 32'h1, 32'h1);
        repeat (10) tick();
        rd(2'd0, "t3_back_data", 32'h3, 32'h3);
        rd(2'd3, "t3_ecap", 32'h2, 32'h2);

        // Write-1-to-clear, and an edge winning over a same-cycle clear.
        in_port = 2'b10;
        repeat (8) tick();
        rd(2'd3, "t4_ecap_both", 32'h3, 32'h3);
        wr(2'd3, 32'h1);
        rd(2'd3, "t4_w1c", 32'h2, 32'h2);
        in_port = 2'b11;
        repeat (10) tick();
        wr(2'd3, 32'h1);
        rd(2'd3, "t4_pre", 32'h2, 32'h2);
        in_port = 2'b10;
        repeat (6) tick();
        wr(2'd3, 32'h1);
        rd(2'd3, "t4_edge_wins", 32'h3, 32'h3);
        chk_irq("t4", 1'b1, 1'b1);

        // Reset in the middle of a debounce with captures pending.
        in_port = 2'b11;
        repeat (10) tick();
        wr(2'd2, 32'h3);
        in_port = 2'b10;
        repeat (4) tick();
        reset = 1'b1; in_port = 2'b11;
        tick();
        reset = 1'b0;
        rd(2'd0, "t6_data", 32'h3, 32'h3);
        rd(2'd2, "t6_mask", 32'h0, 32'h0);
        rd(2'd3, "t6_ecap", 32'h0, 32'h0);
        chk_irq("t6", 1'b0, 1'b0);
        repeat (12) tick();
        rd(2'd3, "t6_no_spurious", 32'h0, 32'h0);
        rd(2'd0, "t6_data_late", 32'h3, 32'h3);
        chk_irq("t6_late", 1'b0, 1'b0);

        // Random run against the reference model.
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                in_port = 2'($urandom);
                hold    = $urandom_range(9, 1);
            end
            hold--;
            cs      = ($urandom % 3) == 0;
            wn      = 1'($urandom);
            address = 2'($urandom);
            wd      = $urandom;
            reset   = ($urandom % 300) == 0;
            tick();
            chk("rnd_rd_falling", bus1.readdata, exp_rd(address, m_ec1));
            chk("rnd_rd_any", bus2.readdata, exp_rd(address, m_ec2));
            chk("rnd_irq_falling", {31'd0, bus1.irq}, {31'd0, |(m_ec1 & m_mask)});
            chk("rnd_irq_any", {31'd0, bus2.irq}, {31'd0, |(m_ec2 & m_mask)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
